// File: rtl/i2c_slave_target_if.sv
// Local-side and pad-side signals of the I2C target, grouped for port hookup.
// The slave modport is the target's view; master is the surrounding logic/pads.
interface i2c_slave_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, tx_req, rx_data, rx_valid, busy
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, tx_req, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/i2c_slave_target.sv
// I2C target: address match, byte receive/transmit, ACK generation; never stretches SCL.
// Pin edges are acted on SYNC_STAGES+1 clk after they occur; no backpressure on the local side.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b0101101,
  parameter int         SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  i2c_slave_target_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;
  logic [2:0]             cnt, cnt_nxt;
  logic [7:0]             sh, sh_nxt, byte_in;
  logic                   rw, rw_nxt, ack_ph, ack_ph_nxt;
  logic                   sda_oe, sda_oe_nxt, tx_req, tx_req_nxt;
  logic                   rx_valid, rx_valid_nxt, busy, busy_nxt;
  logic [7:0]             rx_data, rx_data_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign sda_rise = sda & ~sda_d;
  assign sda_fall = ~sda & sda_d;
  // An SDA edge coinciding with an SCL edge is a data change, so SCL must be stable high.
  assign start_det = sda_fall & scl & scl_d;
  assign stop_det  = sda_rise & scl & scl_d;
  assign byte_in   = {sh[6:0], sda};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      sh       <= 8'h00;
      rw       <= 1'b0;
      ack_ph   <= 1'b0;
      sda_oe   <= 1'b0;
      tx_req   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sh       <= sh_nxt;
      rw       <= rw_nxt;
      ack_ph   <= ack_ph_nxt;
      sda_oe   <= sda_oe_nxt;
      tx_req   <= tx_req_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sh_nxt       = sh;
    rw_nxt       = rw;
    ack_ph_nxt   = ack_ph;
    sda_oe_nxt   = sda_oe;
    tx_req_nxt   = 1'b0;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    busy_nxt     = busy;
    if (start_det) begin
      state_nxt  = ADDR;
      cnt_nxt    = 3'd0;
      sda_oe_nxt = 1'b0;
      ack_ph_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_nxt  = byte_in;
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_nxt  = ADDR_ACK;
              busy_nxt   = 1'b1;
              rw_nxt     = byte_in[0];
              ack_ph_nxt = 1'b0;
            end else begin
              state_nxt = WAIT_STOP;
            end
          end
        end
        // ack_ph separates the 8th fall (start driving ACK) from the 9th fall (end of ACK).
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_ph) begin
            ack_ph_nxt = 1'b1;
            sda_oe_nxt = 1'b1;
          end else begin
            ack_ph_nxt = 1'b0;
            sda_oe_nxt = 1'b0;
            cnt_nxt    = 3'd0;
            if (state == ADDR_ACK && rw) begin
              tx_req_nxt = 1'b1;
              sh_nxt     = bus.tx_data;
              sda_oe_nxt = ~bus.tx_data[7];
              state_nxt  = RD_DATA;
            end else begin
              state_nxt = WR_DATA;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_nxt  = byte_in;
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_data_nxt  = byte_in;
            rx_valid_nxt = 1'b1;
            ack_ph_nxt   = 1'b0;
            state_nxt    = WR_ACK;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (cnt == 3'd7) begin
            sda_oe_nxt = 1'b0;
            cnt_nxt    = 3'd0;
            ack_ph_nxt = 1'b0;
            state_nxt  = RD_ACK;
          end else begin
            sh_nxt     = {sh[6:0], 1'b0};
            sda_oe_nxt = ~sh[6];
            cnt_nxt    = cnt + 3'd1;
          end
        end
        // ack_ph here remembers that the master ACKed at the 9th rise.
        RD_ACK: if (scl_rise) begin
          if (sda) begin
            state_nxt = WAIT_STOP;
            busy_nxt  = 1'b0;
          end else begin
            ack_ph_nxt = 1'b1;
          end
        end else if (scl_fall && ack_ph) begin
          tx_req_nxt = 1'b1;
          sh_nxt     = bus.tx_data;
          sda_oe_nxt = ~bus.tx_data[7];
          ack_ph_nxt = 1'b0;
          cnt_nxt    = 3'd0;
          state_nxt  = RD_DATA;
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe   = sda_oe;
  assign bus.tx_req   = tx_req;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench acting as I2C master against i2c_slave_target; expectations come from a
// transaction-level model (bytes written/read, ACKs, pulse counts) kept in the bench.
module tb_i2c_slave_target;
  localparam logic [6:0] ADDR = 7'b0101101;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [7:0] tx_vals [0:255];
  logic [7:0] tx_idx = 8'd0;
  logic [7:0] rx_log [$];
  int txreq_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int errors = 0;
  int checks = 0;
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  i2c_slave_target_if bus ();
  assign bus.scl_in  = scl_m;
  assign bus.sda_in  = sda_m & ~bus.sda_oe;
  assign bus.tx_data = tx_vals[tx_idx];

  i2c_slave_target dut (.clk(clk), .rst(rst), .bus(bus));

  always @(negedge clk) begin
    if (bus.rx_valid) rx_log.push_back(bus.rx_data);
    if (bus.tx_req) begin
      txreq_cnt = txreq_cnt + 1;
      tx_idx    = tx_idx + 8'd1;
    end
    if (bus.sda_oe) oe_cnt = oe_cnt + 1;
    if (bus.busy) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
    qwait();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    @(negedge clk);
    b = bus.sda_in;
    qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] tb0;
    int         rx0, tq0, oe0, bz0, n;
    logic [6:0] a;
    logic       rw, match;
    logic [7:0] exp_q [$];

    for (int i = 0; i < 256; i++) tx_vals[i] = 8'h00;
    last_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_tx_req", bus.tx_req, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    qwait();

    // 1: single-byte write
    rx0 = rx_log.size();
    i2c_start();
    send_byte({ADDR, 1'b0}, ack); chk("t1_addr_ack", ack, 1);
    chk("t1_busy", bus.busy, 1);
    send_byte(8'hB7, ack); chk("t1_data_ack", ack, 1);
    i2c_stop();
    last_rx = 8'hB7;
    chk("t1_rx_cnt", rx_log.size() - rx0, 1);
    if (rx_log.size() > rx0) chk("t1_rx_val", rx_log[rx0], 8'hB7);
    chk("t1_rx_data", bus.rx_data, 8'hB7);
    chk("t1_busy_end", bus.busy, 0);

    // 2: wrong address
    rx0 = rx_log.size(); oe0 = oe_cnt; bz0 = busy_cnt;
    i2c_start();
    send_byte({7'h2C, 1'b0}, ack); chk("t2_addr_ack", ack, 0);
    send_byte(8'hB7, ack); chk("t2_data_ack", ack, 0);
    i2c_stop();
    chk("t2_oe_cycles", oe_cnt - oe0, 0);
    chk("t2_rx_cnt", rx_log.size() - rx0, 0);
    chk("t2_busy_cycles", busy_cnt - bz0, 0);

    // 3: single-byte read ending in NACK
    tq0 = txreq_cnt; tb0 = tx_idx;
    tx_vals[tb0] = 8'h56;
    i2c_start();
    send_byte({ADDR, 1'b1}, ack); chk("t3_addr_ack", ack, 1);
    recv_byte(d, 1'b0); chk("t3_rd_byte", d, 8'h56);
    chk("t3_oe_after_nack", bus.sda_oe, 0);
    chk("t3_busy_after_nack", bus.busy, 0);
    oe0 = oe_cnt;
    send_byte(8'h5A, ack); chk("t3_waitstop_ack", ack, 0);
    chk("t3_waitstop_oe", oe_cnt - oe0, 0);
    i2c_stop();
    chk("t3_tx_req_cnt", txreq_cnt - tq0, 1);

    // 4: two-byte write, repeated START, two-byte read
    rx0 = rx_log.size(); tq0 = txreq_cnt; tb0 = tx_idx;
    tx_vals[tb0] = 8'hA5; tx_vals[tb0 + 8'd1] = 8'hA5;
    i2c_start();
    send_byte({ADDR, 1'b0}, ack); chk("t4_addr_ack", ack, 1);
    send_byte(8'hB7, ack); chk("t4_d0_ack", ack, 1);
    send_byte(8'h56, ack); chk("t4_d1_ack", ack, 1);
    i2c_start();
    send_byte({ADDR, 1'b1}, ack); chk("t4_raddr_ack", ack, 1);
    recv_byte(d, 1'b1); chk("t4_rd0", d, 8'hA5);
    recv_byte(d, 1'b0); chk("t4_rd1", d, 8'hA5);
    i2c_stop();
    last_rx = 8'h56;
    chk("t4_rx_cnt", rx_log.size() - rx0, 2);
    if (rx_log.size() >= rx0 + 2) begin
      chk("t4_rx0", rx_log[rx0], 8'hB7);
      chk("t4_rx1", rx_log[rx0 + 1], 8'h56);
    end
    chk("t4_tx_req_cnt", txreq_cnt - tq0, 2);

    // 5: STOP in the middle of a write byte
    rx0 = rx_log.size();
    i2c_start();
    send_byte({ADDR, 1'b0}, ack); chk("t5_addr_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    chk("t5_rx_cnt", rx_log.size() - rx0, 0);
    chk("t5_rx_data", bus.rx_data, last_rx);
    chk("t5_sda_oe", bus.sda_oe, 0);
    chk("t5_busy", bus.busy, 0);

    // 6: reset while driving a read bit, then a fresh write
    tb0 = tx_idx;
    tx_vals[tb0] = 8'h00;
    i2c_start();
    send_byte({ADDR, 1'b1}, ack); chk("t6_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) recv_bit(d[0]);
    chk("t6_oe_driving", bus.sda_oe, 1);
    rst = 1'b0;
    #1;
    chk("t6_oe_in_rst", bus.sda_oe, 0);
    chk("t6_rx_in_rst", bus.rx_data, 0);
    last_rx = 8'h00;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(posedge clk);
    rst = 1'b1;
    qwait();
    rx0 = rx_log.size();
    i2c_start();
    send_byte({ADDR, 1'b0}, ack); chk("t6_waddr_ack", ack, 1);
    send_byte(8'h3C, ack); chk("t6_wdata_ack", ack, 1);
    i2c_stop();
    last_rx = 8'h3C;
    chk("t6_rx_cnt", rx_log.size() - rx0, 1);
    chk("t6_rx_data", bus.rx_data, last_rx);

    // randomized transactions
    for (int t = 0; t < 16; t++) begin
      a     = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom);
      rw    = 1'($urandom);
      n     = $urandom_range(1, 3);
      match = (a == ADDR);
      rx0 = rx_log.size(); tq0 = txreq_cnt; oe0 = oe_cnt; tb0 = tx_idx;
      exp_q.delete();
      for (int k = 0; k < n; k++) tx_vals[tb0 + 8'(k)] = 8'($urandom);
      i2c_start();
      send_byte({a, rw}, ack); chk("r_addr_ack", ack, match);
      chk("r_busy", bus.busy, match);
      if (!match) begin
        i2c_stop();
        chk("r_nm_oe", oe_cnt - oe0, 0);
      end else if (!rw) begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          send_byte(d, ack); chk("r_wr_ack", ack, 1);
          exp_q.push_back(d);
          last_rx = d;
        end
        i2c_stop();
      end else begin
        for (int k = 0; k < n; k++) begin
          recv_byte(d, k < n - 1);
          chk("r_rd_byte", d, tx_vals[tb0 + 8'(k)]);
        end
        chk("r_busy_nack", bus.busy, 0);
        i2c_stop();
      end
      chk("r_rx_cnt", rx_log.size() - rx0, exp_q.size());
      for (int k = 0; k < exp_q.size() && rx0 + k < rx_log.size(); k++)
        chk("r_rx_val", rx_log[rx0 + k], exp_q[k]);
      chk("r_tx_req_cnt", txreq_cnt - tq0, (match && rw) ? n : 0);
      chk("r_rx_data", bus.rx_data, last_rx);
      chk("r_busy_end", bus.busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
